// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF challenge/response sequencer:
// bus widths, the controller state encoding and the vote-counter width helper.
package puf_pkg;

    localparam int CHAL_W = 8;
    localparam int RESP_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_FIRE   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Width needed to count 0..num_repeats ones without saturating.
    function automatic int vote_w(input int num_repeats);
        return $clog2(num_repeats + 1);
    endfunction

endpackage

// File: rtl/puf_crp_sequencer_if.sv
// Host-side command/response handshake bundle of the PUF sequencer.
// master = host/scan side, slave = the sequencer.
interface puf_crp_sequencer_if;
    import puf_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CHAL_W-1:0] cmd_challenge;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [RESP_W-1:0] rsp_data;
    logic [RESP_W-1:0] rsp_unstable;
    logic [CHAL_W-1:0] rsp_challenge;
    logic              busy;

    modport master (
        output cmd_valid, cmd_challenge, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_unstable, rsp_challenge, busy
    );

    modport slave (
        input  cmd_valid, cmd_challenge, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_unstable, rsp_challenge, busy
    );

endinterface

// File: rtl/puf_bit_vote.sv
// Per-bit majority voter: counts how many repeats returned a 1 for one
// response bit. The majority/unstable outputs look ahead by including the
// increment of the current cycle, so they are already final during the last
// SAMPLE cycle and the parent can register them on entry to DONE.
module puf_bit_vote
    import puf_pkg::*;
#(
    parameter int NUM_REPEATS = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc_en,
    input  logic bit_in,
    output logic majority,
    output logic unstable
);

    localparam int VOTE_W = vote_w(NUM_REPEATS);

    logic [VOTE_W-1:0] r_ones;
    logic [VOTE_W-1:0] w_ones_next;

    // Count including this cycle's vote, then derive the verdict from it.
    always_comb begin
        w_ones_next = r_ones + VOTE_W'(inc_en && bit_in);
        majority    = w_ones_next > VOTE_W'(NUM_REPEATS / 2);
        unstable    = (w_ones_next != '0) && (w_ones_next != VOTE_W'(NUM_REPEATS));
    end

    // Ones counter, cleared at the start of every new challenge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ones <= '0;
        end else if (clr) begin
            r_ones <= '0;
        end else begin
            r_ones <= w_ones_next;
        end
    end

endmodule

// File: rtl/puf_crp_sequencer.sv
// Challenge/response controller for the 8-bit arbiter-PUF array: accepts a
// challenge, fires the race pulse NUM_REPEATS times, majority-votes the
// synchronised response and returns it with a per-bit instability mask.
module puf_crp_sequencer
    import puf_pkg::*;
#(
    parameter int NUM_REPEATS   = 5,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    puf_crp_sequencer_if.slave  bus,
    output logic [CHAL_W-1:0]   puf_challenge,
    output logic                puf_pulse,
    input  logic [RESP_W-1:0]   puf_response
);

    localparam int VOTE_W = vote_w(NUM_REPEATS);
    // Holds 0..SETTLE_CYCLES+1, the longest (WAIT) phase.
    localparam int TMR_W  = $clog2(SETTLE_CYCLES + 2);

    state_t            r_state;
    state_t            w_next_state;
    logic [TMR_W-1:0]  r_timer;
    logic [VOTE_W-1:0] r_repeats;
    logic [RESP_W-1:0] r_sync1;
    logic [RESP_W-1:0] r_sync2;
    logic [CHAL_W-1:0] r_puf_challenge;
    logic              r_pulse;
    logic [RESP_W-1:0] r_rsp_data;
    logic [RESP_W-1:0] r_rsp_unstable;
    logic [CHAL_W-1:0] r_rsp_challenge;
    logic              w_accept;
    logic              w_sample;
    logic              w_last_repeat;
    logic [RESP_W-1:0] w_majority;
    logic [RESP_W-1:0] w_unstable;

    assign w_accept      = (r_state == ST_IDLE) && bus.cmd_valid;
    assign w_sample      = (r_state == ST_SAMPLE);
    assign w_last_repeat = (r_repeats == VOTE_W'(NUM_REPEATS - 1));

    // Next-state logic: settle, one-cycle race pulse, resolve wait, sample.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (bus.cmd_valid) w_next_state = ST_APPLY;
            ST_APPLY:  if (r_timer == TMR_W'(SETTLE_CYCLES - 1)) w_next_state = ST_FIRE;
            ST_FIRE:   w_next_state = ST_WAIT;
            ST_WAIT:   if (r_timer == TMR_W'(SETTLE_CYCLES + 1)) w_next_state = ST_SAMPLE;
            ST_SAMPLE: w_next_state = w_last_repeat ? ST_DONE : ST_APPLY;
            ST_DONE:   if (bus.rsp_ready) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Phase timer: restarts on every state change, only runs in APPLY/WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if ((r_state != w_next_state) ||
                     !((r_state == ST_APPLY) || (r_state == ST_WAIT))) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    // Repeat counter: cleared on accept, advanced once per SAMPLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_repeats <= '0;
        else if (w_accept) r_repeats <= '0;
        else if (w_sample) r_repeats <= r_repeats + VOTE_W'(1);
    end

    // Race pulse is registered from the next state so it is high exactly in FIRE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pulse <= 1'b0;
        else        r_pulse <= (w_next_state == ST_FIRE);
    end

    // Two-flop synchroniser for the asynchronous PUF response bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= puf_response;
            r_sync2 <= r_sync1;
        end
    end

    // Challenge to the array is held constant from accept to the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_puf_challenge <= '0;
        else if (w_accept) r_puf_challenge <= bus.cmd_challenge;
    end

    // Result registers load on entry to DONE and hold until the next DONE,
    // so an aborted evaluation never leaks a partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data      <= '0;
            r_rsp_unstable  <= '0;
            r_rsp_challenge <= '0;
        end else if (w_sample && w_last_repeat) begin
            r_rsp_data      <= w_majority;
            r_rsp_unstable  <= w_unstable;
            r_rsp_challenge <= r_puf_challenge;
        end
    end

    for (genvar gi = 0; gi < RESP_W; gi++) begin : g_vote
        puf_bit_vote #(
            .NUM_REPEATS (NUM_REPEATS)
        ) u_vote (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (w_accept),
            .inc_en   (w_sample),
            .bit_in   (r_sync2[gi]),
            .majority (w_majority[gi]),
            .unstable (w_unstable[gi])
        );
    end

    assign puf_challenge     = r_puf_challenge;
    assign puf_pulse         = r_pulse;
    assign bus.cmd_ready     = (r_state == ST_IDLE);
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.rsp_valid     = (r_state == ST_DONE);
    assign bus.rsp_data      = r_rsp_data;
    assign bus.rsp_unstable  = r_rsp_unstable;
    assign bus.rsp_challenge = r_rsp_challenge;

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Self-checking bench for puf_crp_sequencer with a behavioural PUF model
// (response = f(challenge) captured on the pulse rise, optional per-repeat flips).
module tb_puf_crp_sequencer;
    import puf_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] puf_challenge;
    logic       puf_pulse;
    logic [7:0] puf_response;

    always #5 clk = ~clk;

    puf_crp_sequencer_if bus();

    puf_crp_sequencer #(
        .NUM_REPEATS   (5),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .puf_challenge (puf_challenge),
        .puf_pulse     (puf_pulse),
        .puf_response  (puf_response)
    );

    typedef struct {
        logic [7:0]      chal;
        logic            inv;
        logic [7:0]      trueResp;
        logic [4:0][7:0] flips;
        logic [7:0]      expData;
        logic [7:0]      expUnstable;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [7:0] unstable;
        logic [7:0] chal;
    } exp_t;

    exp_t sbQ[$];
    vec_t vecs[7];

    int errors = 0;
    int checks = 0;

    // PUF model state
    logic [7:0]      modelTrue;
    logic            modelInvert;
    logic [4:0][7:0] modelFlips;
    logic [7:0]      modelResp;
    int              pulseIdx;

    // Behavioural PUF: evaluates the race when the pulse rises.
    always @(posedge puf_pulse) begin
        modelResp = modelInvert ? ~puf_challenge : modelTrue;
        if (pulseIdx < 5) modelResp = modelResp ^ modelFlips[pulseIdx[2:0]];
        puf_response = modelResp;
        pulseIdx++;
    end

    // Race pulse must never stay high for two cycles.
    aPulse: assert property (@(posedge clk) disable iff (!rst_n) puf_pulse |=> !puf_pulse)
        else begin errors++; $display("[TB] FAIL assert_pulse: puf_pulse high 2 cycles, required single cycle"); end

    // Challenge bus may only move on an accept edge.
    aChal: assert property (@(posedge clk) disable iff (!rst_n)
                            !$stable(puf_challenge) |-> $past(bus.cmd_valid && bus.cmd_ready))
        else begin errors++; $display("[TB] FAIL assert_chal: puf_challenge=0x%0h changed without accept", puf_challenge); end

    // Result data stable under backpressure.
    aStable: assert property (@(posedge clk) disable iff (!rst_n)
                              (bus.rsp_valid && !bus.rsp_ready) |=> $stable(bus.rsp_data))
        else begin errors++; $display("[TB] FAIL assert_stable: rsp_data=0x%0h moved while stalled", bus.rsp_data); end

    function automatic vec_t mk(input logic [7:0] chal, input logic inv, input logic [7:0] tr,
                                input logic [4:0][7:0] fl, input logic [7:0] ed, input logic [7:0] eu);
        vec_t v;
        v.chal = chal; v.inv = inv; v.trueResp = tr; v.flips = fl;
        v.expData = ed; v.expUnstable = eu;
        return v;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one command (called at a negedge), push its expectation on accept.
    task automatic applyStimulus(input vec_t v);
        int n;
        exp_t e;
        modelTrue   = v.trueResp;
        modelInvert = v.inv;
        modelFlips  = v.flips;
        pulseIdx    = 0;
        bus.cmd_valid     = 1'b1;
        bus.cmd_challenge = v.chal;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        compare("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
        @(posedge clk);
        e.data = v.expData; e.unstable = v.expUnstable; e.chal = v.chal;
        sbQ.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Wait for the result, check latency/pulses, optional stall, then handshake.
    task automatic checkOutput(input int holdCycles);
        int   lat;
        exp_t e;
        lat = 0;
        while (!bus.rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        compare("latency", lat, 40);
        compare("pulse_count", pulseIdx, 5);
        if (sbQ.size() == 0) begin
            compare("scoreboard_empty", 1, 0);
            return;
        end
        e = sbQ.pop_front();
        compare("rsp_data", bus.rsp_data, e.data);
        compare("rsp_unstable", bus.rsp_unstable, e.unstable);
        compare("rsp_challenge", bus.rsp_challenge, e.chal);
        if (holdCycles > 0) begin
            bus.cmd_valid     = 1'b1;
            bus.cmd_challenge = ~e.chal;
        end
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            compare("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            compare("hold_data", bus.rsp_data, e.data);
            compare("hold_unstable", bus.rsp_unstable, e.unstable);
            compare("hold_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
            compare("hold_busy", {31'd0, bus.busy}, 32'd1);
            compare("hold_puf_chal", puf_challenge, e.chal);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        compare("post_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        compare("post_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        compare("post_rsp_data_kept", bus.rsp_data, e.data);
    endtask

    task automatic checkResetValues(input string tag);
        compare({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
        compare({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        compare({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        compare({tag, "_puf_pulse"}, {31'd0, puf_pulse}, 32'd0);
        compare({tag, "_puf_chal"}, puf_challenge, 32'd0);
        compare({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
        compare({tag, "_rsp_unstable"}, bus.rsp_unstable, 32'd0);
    endtask

    initial begin
        int n;
        vecs[0] = mk(8'h3C, 1'b0, 8'hA5, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'hA5, 8'h00);
        vecs[1] = mk(8'h3C, 1'b0, 8'hA5, {8'h00, 8'h01, 8'h00, 8'h01, 8'h00}, 8'hA5, 8'h01);
        vecs[2] = mk(8'h3C, 1'b0, 8'hA5, {8'h01, 8'h00, 8'h01, 8'h00, 8'h01}, 8'hA4, 8'h01);
        vecs[3] = mk(8'h00, 1'b1, 8'h00, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'hFF, 8'h00);
        vecs[4] = mk(8'hFF, 1'b1, 8'h00, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 8'h00);
        vecs[5] = mk(8'h5A, 1'b0, 8'h0F, {8'h00, 8'h40, 8'h40, 8'h40, 8'h48}, 8'h4F, 8'h48);
        vecs[6] = mk(8'h5A, 1'b0, 8'h0F, {8'h80, 8'h80, 8'h80, 8'h80, 8'h80}, 8'h8F, 8'h00);

        rst_n             = 1'b0;
        bus.cmd_valid     = 1'b0;
        bus.cmd_challenge = 8'h00;
        bus.rsp_ready     = 1'b0;
        modelTrue         = 8'h00;
        modelInvert       = 1'b0;
        modelFlips        = '0;
        pulseIdx          = 0;
        puf_response      = 8'h00;

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven runs, responses accepted immediately (back-to-back).
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(0);
        end

        // Backpressure: 10 stalled cycles with a competing command request.
        applyStimulus(vecs[0]);
        checkOutput(10);

        // Abort during the WAIT phase of the third repeat.
        applyStimulus(vecs[5]);
        n = 0;
        while (pulseIdx < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        compare("third_pulse_seen", pulseIdx, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetValues("abort");
        void'(sbQ.pop_front());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compare("abort_no_valid", {31'd0, bus.rsp_valid}, 32'd0);
        applyStimulus(vecs[2]);
        checkOutput(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
